mipi_rx_sync_gen: RTL and testbench
===================================

# mipi_rx_sync_gen

Parametrised MIPI receive-side sync generator. It decodes short-packet commands from the MIPI Rx packet parser: frame start (VSS), frame end (VSE), line start (HSS) and line end (HSE). From these it produces Vsync and Hsync pulses of configurable width, a frame-active level, and line and frame counters. It filters on one virtual channel. It sits between the Rx command interface and the pixel-interface timing logic, and replaces the fixed single-cycle Vsync decoder.

## Interface
- VC_SEL, 0: virtual channel accepted (0-3). Commands on other VCs are ignored.
- VS_PULSE_W, 1: Vsync high time in CLKn cycles (1-64).
- HS_PULSE_W, 1: Hsync high time in CLKn cycles (1-64).
- LINE_W, 12: Line_cnt width.
- FRAME_W, 16: Frame_cnt width.

- CLKn  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- Rx_cmd_data_type  in  6  short-packet data type
- Rx_cmd_vc  in  2  virtual channel of the command
- Rx_cmd_valid  in  1  command qualifier, one command per cycle
- Vsync  out  1  frame-start pulse
- Hsync  out  1  line-start pulse
- Frame_active  out  1  high between accepted VSS and VSE
- Line_cnt  out  LINE_W  HSS count in current frame
- Frame_cnt  out  FRAME_W  completed frames (VSE count)
- Err_seq  out  1  single-cycle sequence error (only when MIPI_RX_SYNC_ERR_EN is defined)

## Operation
- A command is accepted when Rx_cmd_valid=1 and Rx_cmd_vc==VC_SEL. Everything else is ignored.
- Decode: 6'h01 VSS, 6'h11 VSE, 6'h21 HSS, 6'h31 HSE. HSE is accepted and has no effect.
- FSM states IDLE and ACTIVE. Reset state is IDLE. Frame_active = (state==ACTIVE).
  - IDLE + VSS -> ACTIVE.
  - ACTIVE + VSE -> IDLE.
  - ACTIVE + VSS -> ACTIVE (new frame, resync).
  - IDLE + VSE -> IDLE.
- Vsync pulse stretcher:
  - An accepted VSS loads the counter with VS_PULSE_W.
  - Vsync is high while the counter is non-zero. The counter decrements each cycle.
  - A VSS arriving during a pulse reloads the counter (retrigger, pulse extended, never truncated).
- Hsync: same stretcher, triggered by HSS in either state, width HS_PULSE_W.
- Line_cnt:
  - Cleared to 0 on VSS.
  - +1 on HSS while ACTIVE. Saturates at all-ones.
  - Not changed by HSS in IDLE.
- Frame_cnt: +1 on VSE while ACTIVE. Wraps modulo 2^FRAME_W.
- Reset value of every output is 0. Asserting RSTn low at any point clears the FSM, counters and stretchers immediately.

## Timing
- Latency of every output update is 1 cycle: the registered response appears on the cycle after the accepted command.
- Vsync is high for exactly VS_PULSE_W cycles after a single VSS. Hsync is high for exactly HS_PULSE_W cycles after a single HSS.
- With VS_PULSE_W=1, Vsync is cycle-identical to the previous fixed decoder: one-cycle pulse, one cycle after VSS.
- Frame_active rises the cycle after VSS and falls the cycle after VSE.
- Line_cnt reads 0 the cycle after VSS, then 1 the cycle after the first HSS.
- Back-to-back commands on consecutive cycles must all be processed. There is no ready/backpressure.

## Configuration
- MIPI_RX_SYNC_ERR_EN defined:
  - Err_seq pulses one cycle, 1 cycle after any of: HSS in IDLE, VSS in ACTIVE, VSE in IDLE.
  - The FSM and counter behaviour are unchanged.
- MIPI_RX_SYNC_ERR_EN undefined: the Err_seq port and the detection logic are absent.

## Structure
- Package mipi_rx_pkg holds:
  - the data-type constants DT_VSS, DT_VSE, DT_HSS, DT_HSE;
  - the FSM state typedef sync_state_t (IDLE, ACTIVE).
- Sub-module mipi_rx_pulse_stretch (parameter WIDTH; ports trig in, pulse out) is instantiated twice, once for Vsync and once for Hsync.

## Test plan
- VS_PULSE_W=1, VSS on VC 0 at cycle 10 -> Vsync high only at cycle 11, Frame_active high from cycle 11.
- VS_PULSE_W=4, VSS at cycle 10 and again at cycle 12 -> Vsync high for cycles 11-16.
- VSS, then 1080 HSS, then VSE -> Line_cnt=1080, Frame_cnt=1, Frame_active low the cycle after VSE.
- VC_SEL=1, VSS/HSS on VC 0 -> no output change. Same sequence on VC 1 -> normal response.
- MIPI_RX_SYNC_ERR_EN defined, HSS in IDLE -> Err_seq high one cycle, Line_cnt stays 0. Second VSS in ACTIVE -> Err_seq pulse and Line_cnt cleared.
- RSTn low mid-frame (Line_cnt=500, Vsync stretching) -> all outputs 0 immediately. After release, a HSS without VSS leaves Line_cnt at 0.

Source files
------------

// File: rtl/mipi_rx_pkg.sv
// Shared definitions for the MIPI Rx sync generator: short-packet data types and FSM states.
package mipi_rx_pkg;

  localparam int unsigned DT_W = 6;

  localparam logic [DT_W-1:0] DT_VSS = 6'h01;
  localparam logic [DT_W-1:0] DT_VSE = 6'h11;
  localparam logic [DT_W-1:0] DT_HSS = 6'h21;
  localparam logic [DT_W-1:0] DT_HSE = 6'h31;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sync_state_t;

endpackage

// File: rtl/mipi_rx_pulse_stretch.sv
// Retriggerable pulse stretcher: pulse is high for WIDTH cycles after the last trig.
module mipi_rx_pulse_stretch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic CLKn,
  input  logic RSTn,
  input  logic trig,
  output logic pulse
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // cnt holds the high cycles still owed after the current one
  logic [CW-1:0] cnt;

  always_ff @(posedge CLKn or negedge RSTn) begin
    if (!RSTn) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (trig) begin
      cnt   <= CW'(WIDTH - 1);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      pulse <= 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/mipi_rx_sync_gen.sv
// MIPI Rx sync generator: VC-filtered VSS/VSE/HSS decode into stretched syncs, frame level and counters.
// Optional sequence-error output enabled by defining MIPI_RX_SYNC_ERR_EN.
module mipi_rx_sync_gen
  import mipi_rx_pkg::*;
#(
  parameter int unsigned VC_SEL     = 0,
  parameter int unsigned VS_PULSE_W = 1,
  parameter int unsigned HS_PULSE_W = 1,
  parameter int unsigned LINE_W     = 12,
  parameter int unsigned FRAME_W    = 16
) (
  input  logic               CLKn,
  input  logic               RSTn,
  input  logic [DT_W-1:0]    Rx_cmd_data_type,
  input  logic [1:0]         Rx_cmd_vc,
  input  logic               Rx_cmd_valid,
  output logic               Vsync,
  output logic               Hsync,
  output logic               Frame_active,
  output logic [LINE_W-1:0]  Line_cnt,
  output logic [FRAME_W-1:0] Frame_cnt
`ifdef MIPI_RX_SYNC_ERR_EN
  ,
  output logic               Err_seq
`endif
);

  sync_state_t state;
  logic        accept_c;
  logic        is_vss_c;
  logic        is_vse_c;
  logic        is_hss_c;

  // Command decode for the selected virtual channel; HSE is accepted but unused
  always_comb begin
    accept_c = Rx_cmd_valid && (Rx_cmd_vc == 2'(VC_SEL));
    is_vss_c = accept_c && (Rx_cmd_data_type == DT_VSS);
    is_vse_c = accept_c && (Rx_cmd_data_type == DT_VSE);
    is_hss_c = accept_c && (Rx_cmd_data_type == DT_HSS);
  end

  always_ff @(posedge CLKn or negedge RSTn) begin
    if (!RSTn) begin
      state        <= IDLE;
      Frame_active <= 1'b0;
      Line_cnt     <= '0;
      Frame_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_vss_c) begin
            state        <= ACTIVE;
            Frame_active <= 1'b1;
          end
        end
        ACTIVE: begin
          if (is_vse_c) begin
            state        <= IDLE;
            Frame_active <= 1'b0;
            Frame_cnt    <= Frame_cnt + FRAME_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          Frame_active <= 1'b0;
        end
      endcase

      // Saturating line count, restarted by every frame start
      if (is_vss_c) begin
        Line_cnt <= '0;
      end else if (is_hss_c && (state == ACTIVE) && (Line_cnt != '1)) begin
        Line_cnt <= Line_cnt + LINE_W'(1);
      end
    end
  end

`ifdef MIPI_RX_SYNC_ERR_EN
  always_ff @(posedge CLKn or negedge RSTn) begin
    if (!RSTn) begin
      Err_seq <= 1'b0;
    end else begin
      Err_seq <= (is_hss_c && (state == IDLE))   ||
                 (is_vss_c && (state == ACTIVE)) ||
                 (is_vse_c && (state == IDLE));
    end
  end
`endif

  mipi_rx_pulse_stretch #(
    .WIDTH (VS_PULSE_W)
  ) u_vs_stretch (
    .CLKn  (CLKn),
    .RSTn  (RSTn),
    .trig  (is_vss_c),
    .pulse (Vsync)
  );

  mipi_rx_pulse_stretch #(
    .WIDTH (HS_PULSE_W)
  ) u_hs_stretch (
    .CLKn  (CLKn),
    .RSTn  (RSTn),
    .trig  (is_hss_c),
    .pulse (Hsync)
  );

endmodule

// File: tb/tb_mipi_rx_sync_gen.sv
// Scoreboard bench for mipi_rx_sync_gen: two configurations driven by shared directed and random commands.
module tb_mipi_rx_sync_gen;

  localparam int unsigned LW_A = 4;
  localparam int unsigned FW_A = 3;
  localparam int unsigned LW_B = 12;
  localparam int unsigned FW_B = 16;

  logic            CLKn = 1'b0;
  logic            RSTn = 1'b0;
  logic [5:0]      dt   = 6'h00;
  logic [1:0]      vc   = 2'd0;
  logic            vld  = 1'b0;

  logic            vs_a, hs_a, fa_a, err_a;
  logic [LW_A-1:0] lc_a;
  logic [FW_A-1:0] fc_a;
  logic            vs_b, hs_b, fa_b, err_b;
  logic [LW_B-1:0] lc_b;
  logic [FW_B-1:0] fc_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit vs;
    bit hs;
    bit fa;
    int lc;
    int fc;
    bit err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 CLKn = ~CLKn;

  mipi_rx_sync_gen #(
    .VC_SEL(1), .VS_PULSE_W(4), .HS_PULSE_W(3), .LINE_W(LW_A), .FRAME_W(FW_A)
  ) dut_a (
    .CLKn(CLKn), .RSTn(RSTn), .Rx_cmd_data_type(dt), .Rx_cmd_vc(vc), .Rx_cmd_valid(vld),
    .Vsync(vs_a), .Hsync(hs_a), .Frame_active(fa_a), .Line_cnt(lc_a), .Frame_cnt(fc_a)
`ifdef MIPI_RX_SYNC_ERR_EN
    , .Err_seq(err_a)
`endif
  );

  mipi_rx_sync_gen #(
    .VC_SEL(0), .VS_PULSE_W(1), .HS_PULSE_W(1), .LINE_W(LW_B), .FRAME_W(FW_B)
  ) dut_b (
    .CLKn(CLKn), .RSTn(RSTn), .Rx_cmd_data_type(dt), .Rx_cmd_vc(vc), .Rx_cmd_valid(vld),
    .Vsync(vs_b), .Hsync(hs_b), .Frame_active(fa_b), .Line_cnt(lc_b), .Frame_cnt(fc_b)
`ifdef MIPI_RX_SYNC_ERR_EN
    , .Err_seq(err_b)
`endif
  );

`ifndef MIPI_RX_SYNC_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: per configuration, tracks frame level, counts and the cycle of the last sync trigger
  initial begin
    int     vc_sel[2], vsw[2], hsw[2], lmax[2], fmod[2];
    bit     act[2];
    int     lc[2], fc[2];
    longint last_vs[2], last_hs[2];
    longint cyc;
    exp_t   e;
    vc_sel = '{1, 0};
    vsw    = '{4, 1};
    hsw    = '{3, 1};
    lmax   = '{(1 << LW_A) - 1, (1 << LW_B) - 1};
    fmod   = '{1 << FW_A, 1 << FW_B};
    cyc    = 0;
    forever begin
      @(posedge CLKn);
      for (int i = 0; i < 2; i++) begin
        bit acc, vss, vse, hss;
        e.err = 1'b0;
        if (!RSTn) begin
          act[i] = 1'b0; lc[i] = 0; fc[i] = 0;
          last_vs[i] = -1000; last_hs[i] = -1000;
        end else begin
          acc = vld && (int'(vc) == vc_sel[i]);
          vss = acc && dt == 6'h01;
          vse = acc && dt == 6'h11;
          hss = acc && dt == 6'h21;
          e.err = (hss && !act[i]) || (vss && act[i]) || (vse && !act[i]);
          if (vss) begin
            last_vs[i] = cyc;
            lc[i] = 0;
            act[i] = 1'b1;
          end
          if (hss) begin
            last_hs[i] = cyc;
            if (act[i] && lc[i] < lmax[i]) lc[i]++;
          end
          if (vse && act[i]) begin
            fc[i] = (fc[i] + 1) % fmod[i];
            act[i] = 1'b0;
          end
        end
        e.vs = (cyc - last_vs[i]) < longint'(vsw[i]);
        e.hs = (cyc - last_hs[i]) < longint'(hsw[i]);
        e.fa = act[i];
        e.lc = lc[i];
        e.fc = fc[i];
        if (i == 0) q_a.push_back(e); else q_b.push_back(e);
      end
      cyc++;
    end
  end

  // Monitor: outputs update every cycle, so pop one expectation per configuration after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLKn);
      #1;
      if (q_a.size() == 0 || q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: expectation queue empty at %0t", $time);
      end else begin
        e = q_a.pop_front();
        check("a.vsync", int'(vs_a), int'(e.vs));
        check("a.hsync", int'(hs_a), int'(e.hs));
        check("a.frame_active", int'(fa_a), int'(e.fa));
        check("a.line_cnt", int'(lc_a), e.lc);
        check("a.frame_cnt", int'(fc_a), e.fc);
`ifdef MIPI_RX_SYNC_ERR_EN
        check("a.err_seq", int'(err_a), int'(e.err));
`endif
        e = q_b.pop_front();
        check("b.vsync", int'(vs_b), int'(e.vs));
        check("b.hsync", int'(hs_b), int'(e.hs));
        check("b.frame_active", int'(fa_b), int'(e.fa));
        check("b.line_cnt", int'(lc_b), e.lc);
        check("b.frame_cnt", int'(fc_b), e.fc);
`ifdef MIPI_RX_SYNC_ERR_EN
        check("b.err_seq", int'(err_b), int'(e.err));
`endif
      end
    end
  end

  task automatic send(input logic [5:0] t, input logic [1:0] c);
    @(negedge CLKn);
    dt = t; vc = c; vld = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLKn);
      vld = 1'b0;
      dt  = 6'($urandom_range(0, 63));
      vc  = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_outputs"}, int'({vs_a, hs_a, fa_a, err_a}), 0);
    check({tag, ".a_counts"}, int'(lc_a) + int'(fc_a), 0);
    check({tag, ".b_outputs"}, int'({vs_b, hs_b, fa_b, err_b}), 0);
    check({tag, ".b_counts"}, int'(lc_b) + int'(fc_b), 0);
  endtask

  initial begin
    logic [5:0] dts[5];
    dts = '{6'h01, 6'h11, 6'h21, 6'h31, 6'h12};
    idle(3);
    check_all_zero("reset");
    @(negedge CLKn);
    RSTn = 1'b1;
    idle(5);

    // Single VSS on each channel, then retrigger of the wide Vsync two cycles apart
    send(6'h01, 2'd0);
    idle(4);
    send(6'h01, 2'd1);
    idle(1);
    send(6'h01, 2'd1);
    idle(8);

    // Full frame of 1080 lines on VC 0; the narrow config on VC 1 saturates its line count
    send(6'h01, 2'd0);
    for (int k = 0; k < 1080; k++) send(6'h21, 2'd0);
    send(6'h31, 2'd0);
    send(6'h11, 2'd0);
    idle(3);
    send(6'h01, 2'd1);
    for (int k = 0; k < 20; k++) send(6'h21, 2'd1);
    send(6'h11, 2'd1);
    send(6'h11, 2'd1);
    send(6'h21, 2'd1);
    idle(5);

    // Random mix of valid/invalid commands across all channels
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLKn);
      vld = ($urandom_range(0, 99) < 60);
      vc  = 2'($urandom_range(0, 3));
      dt  = dts[$urandom_range(0, 4)];
    end
    idle(5);

    // Asynchronous reset mid-frame while Vsync is still stretching
    send(6'h01, 2'd0);
    for (int k = 0; k < 500; k++) send(6'h21, 2'd0);
    send(6'h01, 2'd1);
    send(6'h21, 2'd1);
    @(negedge CLKn);
    vld = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    check_all_zero("async_reset");
    idle(2);
    RSTn = 1'b1;
    send(6'h21, 2'd0);
    send(6'h21, 2'd1);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
